i2c_receiver: RTL
=================

Name: i2c_receiver

Overview:
- I2C write-only target (slave) that receives the 3-byte frames issued by the team's I2C write controller: device address + W, register address, then one or more data bytes.
- Oversamples SCL/SDA on a fast system clock, ACKs matching frames by pulling SDA low, and presents each received byte as register address / data with a one-cycle strobe.
- Serves as the bench-side and on-chip counterpart for loop-back testing of the configuration path.

Parameters:
- SLAVE_ADDR, 7'h1A: 7-bit device address this target answers to.
- DATA_WIDTH, 8: byte width; fixed at 8, no other value is supported.

Ports:
- CLK_50MHZ  input  1  system clock; must be at least 20x the SCL frequency.
- RESET  input  1  asynchronous, active-low reset.
- I2C_SCL  input  1  serial clock from the bus, asynchronous to CLK_50MHZ.
- I2C_SDA_IN  input  1  sampled SDA bus level.
- I2C_SDA_EN  output  1  1 = release SDA (high-Z); 0 = drive SDA low. The wrapper ties the driven value to 0.
- REG_ADDR  output  8  register address of the current data byte.
- DATA  output  8  last received data byte.
- DATA_VALID  output  1  one-cycle strobe; REG_ADDR and DATA are valid while it is high.
- BUSY  output  1  high from an addressed START until STOP.
- ERROR_LED  output  1  sticky flag; set on a read request to SLAVE_ADDR or on a STOP in mid-byte; cleared only by reset.

Behaviour:
- Reset values: I2C_SDA_EN=1, REG_ADDR=0, DATA=0, DATA_VALID=0, BUSY=0, ERROR_LED=0, state=IDLE.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
  - Edges are detected on the synchronized signals.
  - Input-to-detect latency is 3 clocks.
- Bus condition detection:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled MSB-first on each detected SCL rise.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: on START, go to ADDR and clear the bit counter.
- ADDR: shift 8 bits. After the 8th SCL rise:
  - address == SLAVE_ADDR and R/W=0: go to ADDR_ACK and set BUSY=1.
  - address == SLAVE_ADDR and R/W=1: set ERROR_LED and go to IGNORE.
  - address mismatch: go to IGNORE.
- ADDR_ACK: on the next SCL fall, set I2C_SDA_EN=0. Hold it low through the 9th SCL high phase. On the following SCL fall, release (EN=1) and go to REG.
- REG: shift 8 bits, load the pointer into REG_ADDR, then go to REG_ACK (same ACK timing as ADDR_ACK), then DATA.
- DATA: shift 8 bits. On the clock after the 8th SCL rise is detected:
  - DATA is updated and DATA_VALID=1 for exactly one clock.
  - REG_ADDR holds the current pointer.
  - Then go to DATA_ACK.
- DATA_ACK: ACK as above. REG_ADDR auto-increments by 1 (8-bit, 8'hFF wraps to 8'h00) on the releasing SCL fall. Then return to DATA for a burst.
- IGNORE: SDA stays released; only START or STOP are acted on.
- STOP in any state:
  - go to IDLE, set BUSY=0, release SDA.
  - if the bit counter is nonzero (partial byte), set ERROR_LED; the partial byte is discarded and no DATA_VALID is issued.
- START in any non-IDLE state (repeated start):
  - go to ADDR, clear the bit counter, release SDA.
  - BUSY stays 1 until the new address is evaluated.
- START/STOP take priority over bit sampling in the same clock.
- The ACK drive is never asserted while SCL is high on entry; the drive change happens only after an SCL fall.
- Asynchronous reset mid-frame: immediate return to reset values; SDA is released within the reset assertion.

Decomposition:
- Shared package i2c_pkg:
  - state encoding localparams.
  - I2C_WRITE=1'b0 and I2C_READ=1'b1.
  - default SLAVE_ADDR constant 7'h1A, shared with the controller's configuration data.
- One natural sub-module, i2c_bus_sync: the 2-flop synchronizers, edge detection, and START/STOP/SCL_RISE/SCL_FALL pulse generation.
- The FSM, shift register and counters stay in i2c_receiver.

Test Plan:
- Write frame 0x34, 0x0C, 0x5A (addr 0x1A, W) then STOP → ACK at all 3 ninth clocks; one DATA_VALID with REG_ADDR=0x0C, DATA=0x5A; BUSY returns to 0 after STOP.
- Address 0x1B + W, 0x0C, 0x5A → SDA never driven, no DATA_VALID, BUSY=0, ERROR_LED=0.
- Address 0x35 (0x1A, R) → no ACK, ERROR_LED=1, stays 1 until RESET is low.
- Burst 0x34, 0xFF, 0x11, 0x22 → two DATA_VALID strobes: (REG_ADDR=0xFF, DATA=0x11) then (REG_ADDR=0x00, DATA=0x22), showing pointer wrap.
- Frame 0x34, 0x04, then repeated START, then 0x34, 0x06, 0x77 → DATA_VALID with REG_ADDR=0x06, DATA=0x77; no strobe for the aborted frame.
- STOP after 4 bits of a data byte; separately, assert RESET mid-ACK → ERROR_LED=1 with no strobe; after reset, I2C_SDA_EN=1 and all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding, R/W bit values and the
// default target address also used by the write controller's configuration data.
package i2c_pkg;

    localparam logic       I2C_WRITE          = 1'b0;
    localparam logic       I2C_READ           = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h1A;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_REG      = 3'd3;
    localparam logic [2:0] S_REG_ACK  = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;
    localparam logic [2:0] S_DATA_ACK = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_ADDR     = S_ADDR,
        ST_ADDR_ACK = S_ADDR_ACK,
        ST_REG      = S_REG,
        ST_REG_ACK  = S_REG_ACK,
        ST_DATA     = S_DATA,
        ST_DATA_ACK = S_DATA_ACK,
        ST_IGNORE   = S_IGNORE
    } state_t;

    // Address ACK leads to the register pointer; every later ACK leads to data.
    function automatic state_t ack_next(input state_t s);
        return (s == ST_ADDR_ACK) ? ST_REG : ST_DATA;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the system clock and produces registered
// START, STOP, SCL rise and SCL fall pulses plus the matching SDA level.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_scl_rise,
    output logic o_scl_fall
);

    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;
    logic r_start, r_stop, r_scl_rise, r_scl_fall;

    // Flops reset high so an idle bus produces no spurious edges after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
            r_start    <= r_scl_sync & r_scl_hist &  r_sda_hist & ~r_sda_sync;
            r_stop     <= r_scl_sync & r_scl_hist & ~r_sda_hist &  r_sda_sync;
            r_scl_rise <=  r_scl_sync & ~r_scl_hist;
            r_scl_fall <= ~r_scl_sync &  r_scl_hist;
        end
    end

    // r_sda_hist holds the level the pulses were computed from, one clock later.
    assign o_sda      = r_sda_hist;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;

endmodule

// File: rtl/i2c_receiver.sv
// Write-only I2C target: accepts address+W, register pointer and a burst of
// data bytes, ACKs each byte and strobes every data byte out with its pointer.
module i2c_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                  CLK_50MHZ,
    input  logic                  RESET,
    input  logic                  I2C_SCL,
    input  logic                  I2C_SDA_IN,
    output logic                  I2C_SDA_EN,
    output logic [DATA_WIDTH-1:0] REG_ADDR,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  DATA_VALID,
    output logic                  BUSY,
    output logic                  ERROR_LED
);

    logic w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;
    logic [DATA_WIDTH-1:0] w_byte;

    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_ack_phase;

    i2c_bus_sync u_bus_sync (
        .i_clk      (CLK_50MHZ),
        .i_rst_n    (RESET),
        .i_scl      (I2C_SCL),
        .i_sda      (I2C_SDA_IN),
        .o_sda      (w_sda),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall)
    );

    assign w_byte = {r_shift[DATA_WIDTH-2:0], w_sda};

    always_ff @(posedge CLK_50MHZ or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ack_phase <= 1'b0;
            I2C_SDA_EN  <= 1'b1;
            REG_ADDR    <= '0;
            DATA        <= '0;
            DATA_VALID  <= 1'b0;
            BUSY        <= 1'b0;
            ERROR_LED   <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (w_stop) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= '0;
                r_ack_phase <= 1'b0;
                I2C_SDA_EN  <= 1'b1;
                BUSY        <= 1'b0;
                // The SCL rise that sets up a STOP is always counted as one bit,
                // so only two or more counted bits mean a byte was cut short.
                if (r_bit_cnt > 3'd1) begin
                    ERROR_LED <= 1'b1;
                end
            end else if (w_start) begin
                r_state     <= ST_ADDR;
                r_bit_cnt   <= '0;
                r_ack_phase <= 1'b0;
                I2C_SDA_EN  <= 1'b1;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= '0;
                                if (w_byte[7:1] != SLAVE_ADDR) begin
                                    BUSY    <= 1'b0;
                                    r_state <= ST_IGNORE;
                                end else if (w_byte[0] == I2C_READ) begin
                                    ERROR_LED <= 1'b1;
                                    BUSY      <= 1'b0;
                                    r_state   <= ST_IGNORE;
                                end else begin
                                    BUSY    <= 1'b1;
                                    r_state <= ST_ADDR_ACK;
                                end
                            end
                        end
                    end
                    ST_REG: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= '0;
                                REG_ADDR  <= w_byte;
                                r_state   <= ST_REG_ACK;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt  <= '0;
                                DATA       <= w_byte;
                                DATA_VALID <= 1'b1;
                                r_state    <= ST_DATA_ACK;
                            end
                        end
                    end
                    // First fall after the byte starts the ACK, the next ends it,
                    // so SDA only ever changes while SCL is low.
                    ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                I2C_SDA_EN  <= 1'b0;
                                r_ack_phase <= 1'b1;
                            end else begin
                                I2C_SDA_EN  <= 1'b1;
                                r_ack_phase <= 1'b0;
                                r_state     <= ack_next(r_state);
                                if (r_state == ST_DATA_ACK) begin
                                    REG_ADDR <= REG_ADDR + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
